jts16b_sndlatch: RTL and testbench

- Command mailbox between the System 16B main 68000 and the sound Z80; models the sound-latch portion of the 315-5195 mapper.
- Main CPU writes command bytes, and the Z80 reads them through the mapper port (I/O 0xC0 / memory 0xE800).
- `snd_obf` drives the Z80 /INT directly (int_n = ~snd_obf).
- A reply byte path (Z80 → main) is included for games that handshake.

---
 rtl/jts16b_snd_pkg.sv | 15 +
 rtl/jts16b_cmd_fifo.sv | 42 ++++
 rtl/jts16b_sndlatch.sv | 105 ++++++++++
 tb/tb_jts16b_sndlatch.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jts16b_snd_pkg.sv
// jts16b_snd_pkg: shared widths, constants and strobe edge classification for the sound latch.
package jts16b_snd_pkg;

    localparam int          CMD_W          = 8;
    localparam int          SNDLATCH_DEPTH = 4;
    localparam logic [7:0]  EMPTY_BYTE     = 8'hFF;

    typedef enum logic [1:0] {EV_NONE, EV_RISE, EV_FALL} ev_e;

    // An unarmed strobe never reports an edge (it was already high when reset released).
    function automatic ev_e edge_ev(input logic q, input logic p, input logic arm);
        return !arm ? EV_NONE : (q && !p) ? EV_RISE : (!q && p) ? EV_FALL : EV_NONE;
    endfunction

endpackage

// File: rtl/jts16b_cmd_fifo.sv
// jts16b_cmd_fifo: DEPTH-entry command FIFO with head output; a pop frees room for a same-cycle push.
module jts16b_cmd_fifo
    import jts16b_snd_pkg::*;
#(
    parameter int DEPTH = SNDLATCH_DEPTH,
    parameter int AW    = 2
)(
    input  logic             rst_n,
    input  logic             clk,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] din,
    output logic [CMD_W-1:0] head,
    output logic             full,
    output logic             empty
);
    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

endmodule

// File: rtl/jts16b_sndlatch.sv
// jts16b_sndlatch: 68000->Z80 sound command mailbox plus Z80->68000 reply register.
// Define JTS16B_SNDLATCH_FIFO_EN for a DEPTH-entry command FIFO instead of the single PCB latch.
module jts16b_sndlatch
    import jts16b_snd_pkg::*;
#(
    parameter int DEPTH = SNDLATCH_DEPTH,
    parameter int AW    = 2
)(
    input  logic             rst_n,
    input  logic             clk,
    input  logic             main_wr,
    input  logic [CMD_W-1:0] main_din,
    input  logic             main_rd,
    output logic [CMD_W-1:0] main_dout,
    output logic             main_rply,
    output logic             main_ovf,
    input  logic             snd_rd,
    input  logic             snd_wr,
    input  logic [CMD_W-1:0] snd_din,
    output logic [CMD_W-1:0] snd_dout,
    output logic             snd_obf
);
    if (DEPTH < 2 || DEPTH != (1 << AW)) begin : g_cfg_err
        $error("jts16b_sndlatch: DEPTH must equal 2**AW and be at least 2");
    end

    logic [3:0]       q, p, arm;
    logic             live, push, pop, rwr, rclr, lost, nxt_obf;
    logic [CMD_W-1:0] nxt_dout;

    // arm only sets once a low level is seen after reset, so a strobe held through reset is ignored
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            q    <= '0;
            p    <= '0;
            arm  <= '0;
            live <= 1'b0;
        end else begin
            q    <= {main_wr, main_rd, snd_rd, snd_wr};
            p    <= q;
            arm  <= arm | ({4{live}} & ~q);
            live <= 1'b1;
        end

    assign push = edge_ev(q[3], p[3], arm[3]) == EV_RISE;
    assign rclr = edge_ev(q[2], p[2], arm[2]) == EV_FALL;
    assign pop  = edge_ev(q[1], p[1], arm[1]) == EV_FALL;
    assign rwr  = edge_ev(q[0], p[0], arm[0]) == EV_RISE;

`ifdef JTS16B_SNDLATCH_FIFO_EN
    logic [CMD_W-1:0] head;
    logic             full, empty;

    jts16b_cmd_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .rst_n (rst_n),
        .clk   (clk),
        .push  (push),
        .pop   (pop),
        .din   (main_din),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign lost     = push & full & ~pop;
    assign nxt_obf  = ~empty;
    assign nxt_dout = empty ? EMPTY_BYTE : head;
`else
    logic [CMD_W-1:0] latch;
    logic             lfull;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            latch <= EMPTY_BYTE;
            lfull <= 1'b0;
        end else begin
            if (push)       latch <= main_din;
            if (push | pop) lfull <= push;
        end

    assign lost     = push & lfull & ~pop;
    assign nxt_obf  = lfull;
    assign nxt_dout = latch;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            snd_obf   <= 1'b0;
            snd_dout  <= EMPTY_BYTE;
            main_dout <= '0;
            main_rply <= 1'b0;
            main_ovf  <= 1'b0;
        end else begin
            snd_obf  <= nxt_obf;
            snd_dout <= nxt_dout;
            if (lost) main_ovf <= 1'b1;
            if (rwr) begin
                main_dout <= snd_din;
                main_rply <= 1'b1;
            end else if (rclr) begin
                main_rply <= 1'b0;
            end
        end

endmodule

// File: tb/tb_jts16b_sndlatch.sv
// tb_jts16b_sndlatch: vector table, corner-case sequences and a random run against a queue-based model.
module tb_jts16b_sndlatch;
`ifdef JTS16B_SNDLATCH_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif
    localparam int DEPTH = 4;

    typedef enum int {OP_NONE, OP_PUSH, OP_POP, OP_SWR, OP_MRD} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] d;
        logic [7:0] dout;
        logic       obf;
        logic       rply;
        logic [7:0] mdout;
        logic       ovf;
    } vec_t;

    logic       rst_n = 1'b0, clk = 1'b0;
    logic       main_wr = 1'b0, main_rd = 1'b0, snd_rd = 1'b0, snd_wr = 1'b0;
    logic [7:0] main_din = 8'h00, snd_din = 8'h00;
    logic [7:0] main_dout, snd_dout;
    logic       main_rply, main_ovf, snd_obf;

    int errors = 0, checks = 0;

    logic [7:0] mq[$];
    logic [7:0] m_lat, m_mdout;
    logic       m_full, m_ovf, m_rply;

    jts16b_sndlatch #(.DEPTH(DEPTH), .AW(2)) dut (
        .rst_n     (rst_n),
        .clk       (clk),
        .main_wr   (main_wr),
        .main_din  (main_din),
        .main_rd   (main_rd),
        .main_dout (main_dout),
        .main_rply (main_rply),
        .main_ovf  (main_ovf),
        .snd_rd    (snd_rd),
        .snd_wr    (snd_wr),
        .snd_din   (snd_din),
        .snd_dout  (snd_dout),
        .snd_obf   (snd_obf)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
        mq.delete();
        m_lat = 8'hFF; m_full = 1'b0; m_ovf = 1'b0; m_rply = 1'b0; m_mdout = 8'h00;
    endtask

    task automatic do_op(input op_e op, input logic [7:0] d);
        int h = $urandom_range(2, 4);
        case (op)
            OP_PUSH: begin main_din = d; main_wr = 1'b1; step(h); main_wr = 1'b0; end
            OP_POP:  begin snd_rd = 1'b1; step(h); snd_rd = 1'b0; end
            OP_SWR:  begin snd_din = d; snd_wr = 1'b1; step(h); snd_wr = 1'b0; end
            OP_MRD:  begin main_rd = 1'b1; step(h); main_rd = 1'b0; end
            default: ;
        endcase
        step(3);
    endtask

    // Mailbox semantics at the transaction level: a bounded queue, or a one-byte overwrite latch.
    task automatic model(input op_e op, input logic [7:0] d);
        case (op)
            OP_PUSH:
                if (FIFO) begin
                    if (mq.size() < DEPTH) mq.push_back(d);
                    else m_ovf = 1'b1;
                end else begin
                    if (m_full) m_ovf = 1'b1;
                    m_full = 1'b1;
                    m_lat = d;
                end
            OP_POP:
                if (FIFO) begin
                    if (mq.size() > 0) void'(mq.pop_front());
                end else m_full = 1'b0;
            OP_SWR: begin m_mdout = d; m_rply = 1'b1; end
            OP_MRD: m_rply = 1'b0;
            default: ;
        endcase
    endtask

    function automatic logic [7:0] exp_dout();
        return FIFO ? (mq.size() > 0 ? mq[0] : 8'hFF) : m_lat;
    endfunction

    function automatic logic exp_obf();
        return FIFO ? mq.size() > 0 : m_full;
    endfunction

    vec_t tbl[12];
    logic [7:0] seq_c[4];

    initial begin
        tbl = '{
            '{OP_NONE, 8'h00, 8'hFF,                  1'b0,  1'b0, 8'h00, 1'b0},
            '{OP_PUSH, 8'h35, 8'h35,                  1'b1,  1'b0, 8'h00, 1'b0},
            '{OP_POP,  8'h00, FIFO ? 8'hFF : 8'h35,   1'b0,  1'b0, 8'h00, 1'b0},
            '{OP_SWR,  8'hA5, FIFO ? 8'hFF : 8'h35,   1'b0,  1'b1, 8'hA5, 1'b0},
            '{OP_MRD,  8'h00, FIFO ? 8'hFF : 8'h35,   1'b0,  1'b0, 8'hA5, 1'b0},
            '{OP_PUSH, 8'h11, 8'h11,                  1'b1,  1'b0, 8'hA5, 1'b0},
            '{OP_PUSH, 8'h22, FIFO ? 8'h11 : 8'h22,   1'b1,  1'b0, 8'hA5, !FIFO},
            '{OP_POP,  8'h00, 8'h22,                  FIFO,  1'b0, 8'hA5, !FIFO},
            '{OP_POP,  8'h00, FIFO ? 8'hFF : 8'h22,   1'b0,  1'b0, 8'hA5, !FIFO},
            '{OP_SWR,  8'h3C, FIFO ? 8'hFF : 8'h22,   1'b0,  1'b1, 8'h3C, !FIFO},
            '{OP_POP,  8'h00, FIFO ? 8'hFF : 8'h22,   1'b0,  1'b1, 8'h3C, !FIFO},
            '{OP_MRD,  8'h00, FIFO ? 8'hFF : 8'h22,   1'b0,  1'b0, 8'h3C, !FIFO}
        };

        do_reset();
        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i].op, tbl[i].d);
            check($sformatf("v%0d snd_dout", i), snd_dout, tbl[i].dout);
            check($sformatf("v%0d snd_obf", i), snd_obf, tbl[i].obf);
            check($sformatf("v%0d main_rply", i), main_rply, tbl[i].rply);
            check($sformatf("v%0d main_dout", i), main_dout, tbl[i].mdout);
            check($sformatf("v%0d main_ovf", i), main_ovf, tbl[i].ovf);
        end

        // push-to-obf latency and read-cycle stability
        do_reset();
        main_din = 8'h35; main_wr = 1'b1;
        step(1);
        step(1);
        check("lat obf at +1", snd_obf, 1'b0);
        step(1);
        check("lat obf at +2", snd_obf, 1'b1);
        check("lat dout at +2", snd_dout, 8'h35);
        main_wr = 1'b0;
        step(2);
        snd_rd = 1'b1;
        step(4);
        check("read hold dout", snd_dout, 8'h35);
        check("read hold obf", snd_obf, 1'b1);
        snd_rd = 1'b0;
        step(2);
        check("pop obf at +1", snd_obf, 1'b1);
        step(1);
        check("pop obf at +2", snd_obf, 1'b0);
        check("pop dout", snd_dout, FIFO ? 8'hFF : 8'h35);

        // overflow
        do_reset();
        for (int i = 1; i <= 5; i++) do_op(OP_PUSH, 8'(i));
        check("ovf flag", main_ovf, 1'b1);
`ifdef JTS16B_SNDLATCH_FIFO_EN
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain head %0d", i), snd_dout, 8'(i));
            do_op(OP_POP, 8'h00);
        end
        check("drain obf", snd_obf, 1'b0);
        check("drain dout", snd_dout, 8'hFF);

        // simultaneous push and pop on a full FIFO
        do_reset();
        for (int i = 1; i <= 4; i++) do_op(OP_PUSH, 8'(i));
        snd_rd = 1'b1;
        step(3);
        main_din = 8'h55; main_wr = 1'b1; snd_rd = 1'b0;
        step(3);
        main_wr = 1'b0;
        step(3);
        check("sim full ovf", main_ovf, 1'b0);
        check("sim full obf", snd_obf, 1'b1);
        seq_c = '{8'h02, 8'h03, 8'h04, 8'h55};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sim full head %0d", i), snd_dout, seq_c[i]);
            do_op(OP_POP, 8'h00);
        end
        check("sim full empty", snd_obf, 1'b0);

        // simultaneous push and pop on an empty FIFO
        snd_rd = 1'b1;
        step(3);
        main_din = 8'h77; main_wr = 1'b1; snd_rd = 1'b0;
        step(3);
        main_wr = 1'b0;
        step(3);
        check("sim empty obf", snd_obf, 1'b1);
        check("sim empty dout", snd_dout, 8'h77);
        do_op(OP_POP, 8'h00);
        check("sim empty pop", snd_obf, 1'b0);
`else
        check("latch last byte", snd_dout, 8'h05);
        do_op(OP_POP, 8'h00);
        check("latch pop obf", snd_obf, 1'b0);
        check("latch pop dout", snd_dout, 8'h05);
`endif

        // reply write beats reply clear in the same cycle
        do_reset();
        do_op(OP_SWR, 8'hA5);
        main_rd = 1'b1;
        step(3);
        main_rd = 1'b0; snd_din = 8'h5A; snd_wr = 1'b1;
        step(4);
        snd_wr = 1'b0;
        step(3);
        check("rply race flag", main_rply, 1'b1);
        check("rply race data", main_dout, 8'h5A);

        // reset in the middle of a Z80 read
        do_reset();
        do_op(OP_PUSH, 8'h35);
        do_op(OP_SWR, 8'h99);
        snd_rd = 1'b1;
        step(2);
        rst_n = 1'b0;
        #2;
        check("async rst obf", snd_obf, 1'b0);
        check("async rst dout", snd_dout, 8'hFF);
        check("async rst rply", main_rply, 1'b0);
        check("async rst mdout", main_dout, 8'h00);
        step(2);
        rst_n = 1'b1;
        step(3);
        do_op(OP_PUSH, 8'h42);
        check("post rst push obf", snd_obf, 1'b1);
        snd_rd = 1'b0;
        step(4);
        check("no stale pop obf", snd_obf, 1'b1);
        check("no stale pop dout", snd_dout, 8'h42);
        do_op(OP_POP, 8'h00);
        check("post rst pop obf", snd_obf, 1'b0);

        // random transactions against the model
        do_reset();
        for (int i = 0; i < 250; i++) begin
            op_e        op = op_e'($urandom_range(1, 4));
            logic [7:0] d  = 8'($urandom_range(0, 255));
            do_op(op, d);
            model(op, d);
            check($sformatf("rnd%0d snd_dout", i), snd_dout, exp_dout());
            check($sformatf("rnd%0d snd_obf", i), snd_obf, exp_obf());
            check($sformatf("rnd%0d main_rply", i), main_rply, m_rply);
            check($sformatf("rnd%0d main_dout", i), main_dout, m_mdout);
            check($sformatf("rnd%0d main_ovf", i), main_ovf, m_ovf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
